// File: rtl/ss_retire_unit_if.sv
// Retire-side bus between the ROB (master) and ss_retire_unit (slave).
// Sizing comes from `WIDTH, `PRF_SIZE, `RF_SIZE and `XLEN; each defaults if not defined.
`ifndef WIDTH
`define WIDTH 2
`endif
`ifndef PRF_SIZE
`define PRF_SIZE 64
`endif
`ifndef RF_SIZE
`define RF_SIZE 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

interface ss_retire_unit_if;
    localparam int W     = `WIDTH;
    localparam int PRF_W = $clog2(`PRF_SIZE);
    localparam int RF_W  = $clog2(`RF_SIZE);
    localparam int XL    = `XLEN;

    // ROB -> retire unit: head / head+1 entries, one field array per ROB_ENTRY member
    logic [W-1:0]                 ready_to_retire;
    logic [W-1:0][XL-1:0]         entry_pc;
    logic [W-1:0][RF_W-1:0]       entry_dest;
    logic [W-1:0][PRF_W-1:0]      entry_tag;
    logic [W-1:0][PRF_W-1:0]      entry_tag_old;
    logic [W-1:0]                 entry_wr_mem;
    logic [W-1:0]                 entry_halt;
    logic                         rollback;
    logic                         st_commit_ack;

    logic [W-1:0]                 retire_en;
    logic [W-1:0]                 free_valid;
    logic [W-1:0][PRF_W-1:0]      free_tag;
    logic [W-1:0]                 arch_we;
    logic [W-1:0][RF_W-1:0]       arch_idx;
    logic [W-1:0][PRF_W-1:0]      arch_tag;
    logic                         st_commit_valid;
    logic [XL-1:0]                st_commit_pc;
    logic                         halted;
    logic [1:0]                   state_dbg;

    modport master (
        output ready_to_retire, entry_pc, entry_dest, entry_tag, entry_tag_old,
               entry_wr_mem, entry_halt, rollback, st_commit_ack,
        input  retire_en, free_valid, free_tag, arch_we, arch_idx, arch_tag,
               st_commit_valid, st_commit_pc, halted, state_dbg
    );

    modport slave (
        input  ready_to_retire, entry_pc, entry_dest, entry_tag, entry_tag_old,
               entry_wr_mem, entry_halt, rollback, st_commit_ack,
        output retire_en, free_valid, free_tag, arch_we, arch_idx, arch_tag,
               st_commit_valid, st_commit_pc, halted, state_dbg
    );
endinterface

// File: rtl/ss_retire_unit.sv
// Two-wide retire stage: frees old tags, writes the arch map, commits stores, latches halt.
// Optional RETIRE_PERF_EN adds retired_cnt / stall_cnt performance counters.
`ifndef WIDTH
`define WIDTH 2
`endif
`ifndef PRF_SIZE
`define PRF_SIZE 64
`endif
`ifndef RF_SIZE
`define RF_SIZE 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

module ss_retire_unit (
    input  logic            clk,
    input  logic            reset,
    ss_retire_unit_if.slave rif
`ifdef RETIRE_PERF_EN
    ,
    output logic [63:0]     retired_cnt,
    output logic [31:0]     stall_cnt
`endif
);
    localparam int WIDTH = `WIDTH;
    localparam int PRF_W = $clog2(`PRF_SIZE);
    localparam int RF_W  = $clog2(`RF_SIZE);
    localparam int XL    = `XLEN;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ST_WAIT = 2'd1,
        S_FLUSH   = 2'd2,
        S_HALT    = 2'd3
    } state_t;

    state_t                      r_state;
    logic                        r_halted;
    logic                        r_st_valid;
    logic [XL-1:0]               r_st_pc;

    state_t                      w_next_state;
    logic [WIDTH-1:0]            w_retire_en;
    logic [WIDTH-1:0]            w_free_valid;
    logic [WIDTH-1:0][PRF_W-1:0] w_free_tag;
    logic [WIDTH-1:0][RF_W-1:0]  w_arch_idx;
    logic [WIDTH-1:0][PRF_W-1:0] w_arch_tag;

    // Retire decision. Slot 1 only ever joins a plain slot-0 retirement, so
    // retire_en stays contiguous from bit 0.
    always_comb begin
        w_retire_en  = '0;
        w_next_state = r_state;
        if (!reset) begin
            if (r_state == S_FLUSH) begin
                w_next_state = S_IDLE;
            end else if (rif.ready_to_retire[0]) begin
                case (r_state)
                    S_IDLE: begin
                        if (!r_halted) begin
                            if (rif.rollback) begin
                                w_retire_en  = 2'b01;
                                w_next_state = S_FLUSH;
                            end else if (rif.entry_wr_mem[0]) begin
                                w_next_state = S_ST_WAIT;
                            end else if (rif.entry_halt[0]) begin
                                w_retire_en  = 2'b01;
                                w_next_state = S_HALT;
                            end else begin
                                w_retire_en[0] = 1'b1;
                                w_retire_en[1] = rif.ready_to_retire[1] &&
                                                 !rif.entry_wr_mem[1] &&
                                                 !rif.entry_halt[1];
                            end
                        end
                    end
                    S_ST_WAIT: begin
                        if (rif.st_commit_ack) begin
                            w_retire_en  = 2'b01;
                            w_next_state = S_IDLE;
                        end
                    end
                    default: begin
                        w_retire_en = '0;
                    end
                endcase
            end
        end
    end

    // Freelist / arch-map side: fields are zeroed for slots that do not retire.
    always_comb begin
        w_free_valid = '0;
        w_free_tag   = '0;
        w_arch_idx   = '0;
        w_arch_tag   = '0;
        for (int w = 0; w < WIDTH; w++) begin
            if (w_retire_en[w]) begin
                w_free_valid[w] = (rif.entry_dest[w] != '0);
                w_free_tag[w]   = rif.entry_tag_old[w];
                w_arch_idx[w]   = rif.entry_dest[w];
                w_arch_tag[w]   = rif.entry_tag[w];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_halted   <= 1'b0;
            r_st_valid <= 1'b0;
            r_st_pc    <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE && w_next_state == S_ST_WAIT) begin
                r_st_valid <= 1'b1;
                r_st_pc    <= rif.entry_pc[0];
            end else if (r_state == S_ST_WAIT && w_next_state == S_IDLE) begin
                r_st_valid <= 1'b0;
            end
            if (w_next_state == S_HALT) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign rif.retire_en       = w_retire_en;
    assign rif.free_valid      = w_free_valid;
    assign rif.free_tag        = w_free_tag;
    assign rif.arch_we         = w_free_valid;
    assign rif.arch_idx        = w_arch_idx;
    assign rif.arch_tag        = w_arch_tag;
    assign rif.st_commit_valid = r_st_valid;
    assign rif.st_commit_pc    = r_st_pc;
    assign rif.halted          = r_halted;
    assign rif.state_dbg       = r_state;

`ifdef RETIRE_PERF_EN
    logic [63:0] r_retired_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_retired_cnt <= '0;
            r_stall_cnt   <= '0;
        end else begin
            r_retired_cnt <= r_retired_cnt + 64'(w_retire_en[0]) + 64'(w_retire_en[1]);
            if (rif.ready_to_retire[0] && !w_retire_en[0]) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign retired_cnt = r_retired_cnt;
    assign stall_cnt   = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ss_retire_unit.sv
// Directed bench for ss_retire_unit: hand-computed vectors per scenario.
`timescale 1ns/1ps
module tb_ss_retire_unit;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    ss_retire_unit_if rif();

`ifdef RETIRE_PERF_EN
    logic [63:0] retired_cnt;
    logic [31:0] stall_cnt;
`endif

    ss_retire_unit dut (
        .clk   (clk),
        .reset (reset),
        .rif   (rif)
`ifdef RETIRE_PERF_EN
        ,
        .retired_cnt (retired_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; checks follow 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_slots();
        rif.ready_to_retire = '0;
        rif.entry_pc        = '0;
        rif.entry_dest      = '0;
        rif.entry_tag       = '0;
        rif.entry_tag_old   = '0;
        rif.entry_wr_mem    = '0;
        rif.entry_halt      = '0;
        rif.rollback        = 1'b0;
        rif.st_commit_ack   = 1'b0;
    endtask

    task automatic set_slot(input int w, input logic [31:0] pc, input logic [4:0] dest,
                            input logic [5:0] tag, input logic [5:0] told,
                            input logic st, input logic hlt);
        rif.entry_pc[w]      = pc;
        rif.entry_dest[w]    = dest;
        rif.entry_tag[w]     = tag;
        rif.entry_tag_old[w] = told;
        rif.entry_wr_mem[w]  = st;
        rif.entry_halt[w]    = hlt;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_slots();
        set_slot(0, 32'h10, 5'd1, 6'd7, 6'd8, 1'b0, 1'b0);
        set_slot(1, 32'h14, 5'd2, 6'd9, 6'd10, 1'b0, 1'b0);
        rif.ready_to_retire = 2'b11;
        repeat (2) tick();
        #1;
        n_checks++;
        if (rif.retire_en !== 2'b00) $display("FAIL reset_retire_en got %b exp 00", rif.retire_en);
        else n_pass++;
        n_checks++;
        if ({rif.free_valid, rif.arch_we} !== 4'b0000)
            $display("FAIL reset_free_arch got %b exp 0000", {rif.free_valid, rif.arch_we});
        else n_pass++;
        n_checks++;
        if ({rif.st_commit_valid, rif.halted, rif.state_dbg} !== 4'b0000)
            $display("FAIL reset_regs got %b exp 0000", {rif.st_commit_valid, rif.halted, rif.state_dbg});
        else n_pass++;
        n_checks++;
        if (rif.st_commit_pc !== 32'h0) $display("FAIL reset_st_pc got %h exp 0", rif.st_commit_pc);
        else n_pass++;
`ifdef RETIRE_PERF_EN
        n_checks++;
        if (retired_cnt !== 64'd0 || stall_cnt !== 32'd0)
            $display("FAIL reset_perf got %0d/%0d exp 0/0", retired_cnt, stall_cnt);
        else n_pass++;
`endif
        reset = 1'b0;
        clear_slots();
        tick();
    endtask

    task automatic test_dual_alu();
        set_slot(0, 32'h100, 5'd5, 6'd12, 6'd3, 1'b0, 1'b0);
        set_slot(1, 32'h104, 5'd6, 6'd13, 6'd4, 1'b0, 1'b0);
        rif.ready_to_retire = 2'b11;
        #1;
        n_checks++;
        if ({rif.retire_en, rif.free_valid, rif.arch_we} !== 6'b111111)
            $display("FAIL dual_en got %b exp 111111", {rif.retire_en, rif.free_valid, rif.arch_we});
        else n_pass++;
        n_checks++;
        if (rif.free_tag !== {6'd4, 6'd3}) $display("FAIL dual_free_tag got %h exp %h", rif.free_tag, {6'd4, 6'd3});
        else n_pass++;
        n_checks++;
        if (rif.arch_idx !== {5'd6, 5'd5}) $display("FAIL dual_arch_idx got %h exp %h", rif.arch_idx, {5'd6, 5'd5});
        else n_pass++;
        n_checks++;
        if (rif.arch_tag !== {6'd13, 6'd12}) $display("FAIL dual_arch_tag got %h exp %h", rif.arch_tag, {6'd13, 6'd12});
        else n_pass++;
        tick();
        clear_slots();
        #1;
        n_checks++;
        if ({rif.retire_en, rif.free_valid, rif.free_tag, rif.state_dbg} !== 18'd0)
            $display("FAIL idle_zero got %h exp 0", {rif.retire_en, rif.free_valid, rif.free_tag, rif.state_dbg});
        else n_pass++;
        tick();
    endtask

    task automatic test_x0_dest();
        set_slot(0, 32'h108, 5'd0, 6'd20, 6'd21, 1'b0, 1'b0);
        set_slot(1, 32'h10c, 5'd9, 6'd22, 6'd23, 1'b0, 1'b0);
        rif.ready_to_retire = 2'b11;
        #1;
        n_checks++;
        if ({rif.retire_en, rif.free_valid, rif.arch_we} !== 6'b111010)
            $display("FAIL x0_en got %b exp 111010", {rif.retire_en, rif.free_valid, rif.arch_we});
        else n_pass++;
        tick();
        clear_slots();
        // ack with no store outstanding must not start anything
        rif.st_commit_ack = 1'b1;
        tick();
        rif.st_commit_ack = 1'b0;
        #1;
        n_checks++;
        if ({rif.st_commit_valid, rif.state_dbg, rif.retire_en} !== 5'b00000)
            $display("FAIL stray_ack got %b exp 00000", {rif.st_commit_valid, rif.state_dbg, rif.retire_en});
        else n_pass++;
        tick();
    endtask

    task automatic test_store_commit();
        set_slot(0, 32'h40, 5'd0, 6'd0, 6'd0, 1'b1, 1'b0);
        rif.ready_to_retire = 2'b01;
        #1;
        n_checks++;
        if ({rif.retire_en, rif.st_commit_valid} !== 3'b000)
            $display("FAIL st_issue got %b exp 000", {rif.retire_en, rif.st_commit_valid});
        else n_pass++;
        tick();
        set_slot(1, 32'h44, 5'd3, 6'd30, 6'd31, 1'b0, 1'b0);
        rif.ready_to_retire = 2'b11;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if ({rif.st_commit_valid, rif.retire_en, rif.state_dbg} !== 5'b10001 || rif.st_commit_pc !== 32'h40)
                $display("FAIL st_wait%0d got v/en/st=%b pc=%h exp 10001 pc=40", c,
                         {rif.st_commit_valid, rif.retire_en, rif.state_dbg}, rif.st_commit_pc);
            else n_pass++;
            tick();
        end
        rif.st_commit_ack = 1'b1;
        #1;
        n_checks++;
        if ({rif.retire_en, rif.free_valid} !== 4'b0100)
            $display("FAIL st_ack got %b exp 0100", {rif.retire_en, rif.free_valid});
        else n_pass++;
        tick();
        clear_slots();
        #1;
        n_checks++;
        if ({rif.st_commit_valid, rif.state_dbg} !== 3'b000)
            $display("FAIL st_done got %b exp 000", {rif.st_commit_valid, rif.state_dbg});
        else n_pass++;
        tick();
    endtask

    task automatic test_rollback();
        set_slot(0, 32'h200, 5'd7, 6'd14, 6'd15, 1'b0, 1'b0);
        set_slot(1, 32'h204, 5'd8, 6'd16, 6'd17, 1'b0, 1'b0);
        rif.ready_to_retire = 2'b11;
        rif.rollback = 1'b1;
        #1;
        n_checks++;
        if (rif.retire_en !== 2'b01 || rif.free_tag !== {6'd0, 6'd15})
            $display("FAIL rb_retire got en=%b ft=%h exp 01 ft=00f", rif.retire_en, rif.free_tag);
        else n_pass++;
        tick();
        rif.rollback = 1'b0;
        set_slot(0, 32'h300, 5'd10, 6'd40, 6'd41, 1'b0, 1'b0);
        set_slot(1, 32'h304, 5'd11, 6'd42, 6'd43, 1'b0, 1'b0);
        #1;
        n_checks++;
        if ({rif.retire_en, rif.state_dbg} !== 4'b0010)
            $display("FAIL rb_flush got %b exp 0010", {rif.retire_en, rif.state_dbg});
        else n_pass++;
        tick();
        #1;
        n_checks++;
        if (rif.retire_en !== 2'b11) $display("FAIL rb_resume got %b exp 11", rif.retire_en);
        else n_pass++;
        tick();
        clear_slots();
        tick();
    endtask

    task automatic test_slot1_store();
        set_slot(0, 32'h7c, 5'd8, 6'd30, 6'd31, 1'b0, 1'b0);
        set_slot(1, 32'h80, 5'd0, 6'd0, 6'd0, 1'b1, 1'b0);
        rif.ready_to_retire = 2'b11;
        #1;
        n_checks++;
        if (rif.retire_en !== 2'b01 || rif.arch_idx !== {5'd0, 5'd8})
            $display("FAIL s1st_defer got en=%b idx=%h exp 01 idx=008", rif.retire_en, rif.arch_idx);
        else n_pass++;
        tick();
        set_slot(0, 32'h80, 5'd0, 6'd0, 6'd0, 1'b1, 1'b0);
        set_slot(1, 32'h84, 5'd11, 6'd32, 6'd33, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (rif.retire_en !== 2'b00) $display("FAIL s1st_issue got %b exp 00", rif.retire_en);
        else n_pass++;
        tick();
        rif.st_commit_ack = 1'b1;
        #1;
        n_checks++;
        if ({rif.st_commit_valid, rif.retire_en} !== 3'b101 || rif.st_commit_pc !== 32'h80)
            $display("FAIL s1st_ack got v/en=%b pc=%h exp 101 pc=80", {rif.st_commit_valid, rif.retire_en},
                     rif.st_commit_pc);
        else n_pass++;
        tick();
        clear_slots();
        #1;
        n_checks++;
        if (rif.st_commit_valid !== 1'b0) $display("FAIL s1st_drop got %b exp 0", rif.st_commit_valid);
        else n_pass++;
        tick();
    endtask

    task automatic test_halt();
        set_slot(0, 32'h400, 5'd9, 6'd20, 6'd21, 1'b0, 1'b0);
        set_slot(1, 32'h404, 5'd0, 6'd0, 6'd0, 1'b0, 1'b1);
        rif.ready_to_retire = 2'b11;
        #1;
        n_checks++;
        if (rif.retire_en !== 2'b01) $display("FAIL halt_s1_defer got %b exp 01", rif.retire_en);
        else n_pass++;
        tick();
        set_slot(0, 32'h404, 5'd0, 6'd0, 6'd0, 1'b0, 1'b1);
        set_slot(1, 32'h408, 5'd12, 6'd24, 6'd25, 1'b0, 1'b0);
        #1;
        n_checks++;
        if ({rif.retire_en, rif.halted} !== 3'b010) $display("FAIL halt_retire got %b exp 010", {rif.retire_en, rif.halted});
        else n_pass++;
        for (int c = 0; c < 10; c++) begin
            tick();
            #1;
            n_checks++;
            if ({rif.retire_en, rif.halted, rif.state_dbg} !== 5'b00111)
                $display("FAIL halt_hold%0d got %b exp 00111", c, {rif.retire_en, rif.halted, rif.state_dbg});
            else n_pass++;
        end
        tick();
`ifdef RETIRE_PERF_EN
        #1;
        n_checks++;
        if (retired_cnt !== 64'd12) $display("FAIL perf_retired got %0d exp 12", retired_cnt);
        else n_pass++;
        n_checks++;
        if (stall_cnt !== 32'd16) $display("FAIL perf_stall got %0d exp 16", stall_cnt);
        else n_pass++;
`endif
        reset = 1'b1;
        #1;
        n_checks++;
        if (rif.retire_en !== 2'b00) $display("FAIL halt_rst_comb got %b exp 00", rif.retire_en);
        else n_pass++;
        tick();
        #1;
        n_checks++;
        if ({rif.halted, rif.state_dbg} !== 3'b000) $display("FAIL halt_rst got %b exp 000", {rif.halted, rif.state_dbg});
        else n_pass++;
        reset = 1'b0;
        clear_slots();
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        clear_slots();
        test_reset();
        test_dual_alu();
        test_x0_dest();
        test_store_commit();
        test_rollback();
        test_slot1_store();
        test_halt();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
